// File: rtl/rf_write_queue_if.sv
// Producer / drain / forwarding signal bundle for rf_write_queue.
// master: producer, write-port arbiter and readers. slave: the queue itself.
interface rf_write_queue_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 128,
    parameter int QDEPTH = 4
);
    localparam int AW  = $clog2(DEPTH);
    localparam int QAW = $clog2(QDEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    in_addr;
    logic [WIDTH-1:0] in_data;
    logic             drain_en;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [AW-1:0]    raddr0;
    logic             fwd_hit0;
    logic [WIDTH-1:0] fwd_data0;
    logic [AW-1:0]    raddr1;
    logic             fwd_hit1;
    logic [WIDTH-1:0] fwd_data1;
    logic [QAW:0]     count;
    logic             empty;
    logic             full;

    modport master (
        output in_valid, in_addr, in_data, drain_en, raddr0, raddr1,
        input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_hit0, fwd_data0,
               fwd_hit1, fwd_data1, count, empty, full
    );

    modport slave (
        input  in_valid, in_addr, in_data, drain_en, raddr0, raddr1,
        output in_ready, rf_we, rf_waddr, rf_wdata, fwd_hit0, fwd_data0,
               fwd_hit1, fwd_data1, count, empty, full
    );
endinterface

// File: rtl/rf_write_queue.sv
// In-order write queue feeding the register file write port, with read forwarding.
// Optional RF_WQ_X0_FILTER_EN: writes to register 0 are dropped and never forwarded.
module rf_write_queue #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 128,
    parameter int QDEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    rf_write_queue_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int QAW = $clog2(QDEPTH);

    logic [AW-1:0]    addr_mem [QDEPTH];
    logic [WIDTH-1:0] data_mem [QDEPTH];
    logic [QAW-1:0]   head;
    logic [QAW-1:0]   tail;
    logic [QAW:0]     occ;

    logic is_full;
    logic is_empty;
    logic push;
    logic alloc;
    logic pop;

    logic [AW-1:0]    raddr    [2];
    logic             fwd_hit  [2];
    logic [WIDTH-1:0] fwd_data [2];

    always_comb begin
        is_full  = (occ == (QAW+1)'(QDEPTH));
        is_empty = (occ == '0);
        push     = bus.in_valid && !is_full;
        pop      = !is_empty && bus.drain_en;
`ifdef RF_WQ_X0_FILTER_EN
        // Register 0 requests still handshake but never occupy a slot.
        alloc    = push && (bus.in_addr != '0);
`else
        alloc    = push;
`endif
    end

    assign bus.in_ready = !is_full;
    assign bus.rf_we    = pop;
    assign bus.rf_waddr = addr_mem[head];
    assign bus.rf_wdata = data_mem[head];
    assign bus.count    = occ;
    assign bus.empty    = is_empty;
    assign bus.full     = is_full;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (alloc) tail <= tail + 1'b1;
            if (pop)   head <= head + 1'b1;
            if (alloc && !pop)      occ <= occ + 1'b1;
            else if (!alloc && pop) occ <= occ - 1'b1;
        end
    end

    // NOTE: entry storage has no reset; occ alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_mem[tail] <= bus.in_addr;
            data_mem[tail] <= bus.in_data;
        end
    end

    assign raddr[0] = bus.raddr0;
    assign raddr[1] = bus.raddr1;

    // Walk oldest to newest so the last match (closest to tail) wins.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            fwd_hit[p]  = 1'b0;
            fwd_data[p] = '0;
            for (int i = 0; i < QDEPTH; i++) begin
                if (((QAW+1)'(i) < occ) && (addr_mem[head + QAW'(i)] == raddr[p])) begin
                    fwd_hit[p]  = 1'b1;
                    fwd_data[p] = data_mem[head + QAW'(i)];
                end
            end
`ifdef RF_WQ_X0_FILTER_EN
            if (raddr[p] == '0) begin
                fwd_hit[p]  = 1'b0;
                fwd_data[p] = '0;
            end
`endif
        end
    end

    assign bus.fwd_hit0  = fwd_hit[0];
    assign bus.fwd_data0 = fwd_data[0];
    assign bus.fwd_hit1  = fwd_hit[1];
    assign bus.fwd_data1 = fwd_data[1];
endmodule

// File: tb/tb_rf_write_queue.sv
// Self-checking bench for rf_write_queue: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_rf_write_queue;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 128;
    localparam int QDEPTH = 4;
    localparam int AW     = 7;

`ifdef RF_WQ_X0_FILTER_EN
    localparam int BASE = 1;
`else
    localparam int BASE = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_write_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .QDEPTH(QDEPTH)) bus ();

    rf_write_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .QDEPTH(QDEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } ent_t;

    ent_t mq[$];
    logic pend_push;
    logic pend_pop;
    ent_t pend_ent;

    function automatic void model_fwd(input logic [AW-1:0] ra, output logic hit,
                                      output logic [WIDTH-1:0] d);
        hit = 1'b0;
        d   = '0;
        foreach (mq[i]) begin
            if (mq[i].addr == ra) begin
                hit = 1'b1;
                d   = mq[i].data;
            end
        end
`ifdef RF_WQ_X0_FILTER_EN
        if (ra == '0) begin
            hit = 1'b0;
            d   = '0;
        end
`endif
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int sz;
        logic h0, h1;
        logic [WIDTH-1:0] d0, d1;
        sz = mq.size();
        check("m_count", 64'(bus.count), 64'(sz));
        check("m_empty", 64'(bus.empty), 64'(sz == 0));
        check("m_full", 64'(bus.full), 64'(sz == QDEPTH));
        check("m_in_ready", 64'(bus.in_ready), 64'(sz < QDEPTH));
        check("m_rf_we", 64'(bus.rf_we), 64'(sz > 0 && bus.drain_en));
        if (sz > 0) begin
            check("m_rf_waddr", 64'(bus.rf_waddr), 64'(mq[0].addr));
            check("m_rf_wdata", 64'(bus.rf_wdata), 64'(mq[0].data));
        end
        model_fwd(bus.raddr0, h0, d0);
        model_fwd(bus.raddr1, h1, d1);
        check("m_fwd_hit0", 64'(bus.fwd_hit0), 64'(h0));
        check("m_fwd_data0", 64'(bus.fwd_data0), 64'(d0));
        check("m_fwd_hit1", 64'(bus.fwd_hit1), 64'(h1));
        check("m_fwd_data1", 64'(bus.fwd_data1), 64'(d1));
        pend_pop      = (sz > 0) && bus.drain_en;
        pend_push     = bus.in_valid && (sz < QDEPTH);
`ifdef RF_WQ_X0_FILTER_EN
        pend_push     = pend_push && (bus.in_addr != '0);
`endif
        pend_ent.addr = bus.in_addr;
        pend_ent.data = bus.in_data;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else begin
            if (pend_pop && mq.size() > 0) void'(mq.pop_front());
            if (pend_push) mq.push_back(pend_ent);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input int a, input logic [WIDTH-1:0] d);
        bus.in_valid = v;
        bus.in_addr  = AW'(a);
        bus.in_data  = d;
    endtask

    task automatic flush();
        set_in(1'b0, 0, '0);
        bus.drain_en = 1'b1;
        repeat (QDEPTH + 1) step();
        bus.drain_en = 1'b0;
        #1;
        check("flush_empty", 64'(bus.empty), 64'd1);
    endtask

    initial begin
        set_in(1'b0, 0, '0);
        bus.drain_en = 1'b0;
        bus.raddr0   = '0;
        bus.raddr1   = '0;
        repeat (2) step();
        rst = 1'b0;
        step();
        check("reset_count", 64'(bus.count), 64'd0);
        check("reset_empty", 64'(bus.empty), 64'd1);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);

        // Asynchronous reset with three queued writes.
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 40 + i, 32'hC0 + i);
            step();
        end
        set_in(1'b0, 0, '0);
        bus.raddr0 = 7'd40;
        bus.raddr1 = 7'd42;
        @(negedge clk);
        #2;
        check("pre_rst_count", 64'(bus.count), 64'd3);
        rst = 1'b1;
        bus.drain_en = 1'b1;
        #1;
        check("async_rst_count", 64'(bus.count), 64'd0);
        check("async_rst_empty", 64'(bus.empty), 64'd1);
        check("async_rst_rf_we", 64'(bus.rf_we), 64'd0);
        check("async_rst_hit0", 64'(bus.fwd_hit0), 64'd0);
        check("async_rst_hit1", 64'(bus.fwd_hit1), 64'd0);
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("post_rst_rf_we", 64'(bus.rf_we), 64'd0);
            step();
        end
        bus.drain_en = 1'b0;

        // Fill to full, stall a fifth push, then drain in order.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 5 + i, 32'hA5 + i);
            step();
        end
        set_in(1'b1, 9, 32'hA9);
        #1;
        check("fill_full", 64'(bus.full), 64'd1);
        check("fill_in_ready", 64'(bus.in_ready), 64'd0);
        step();
        check("fill_stall_count", 64'(bus.count), 64'd4);
        set_in(1'b0, 0, '0);
        bus.drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_rf_we", 64'(bus.rf_we), 64'd1);
            check("drain_waddr", 64'(bus.rf_waddr), 64'(5 + i));
            check("drain_wdata", 64'(bus.rf_wdata), 64'(32'hA5 + i));
            step();
        end
        check("drain_empty", 64'(bus.empty), 64'd1);
        bus.drain_en = 1'b0;

        // Forward priority on duplicate addresses.
        set_in(1'b1, 3, 32'h11);
        step();
        set_in(1'b1, 3, 32'h22);
        step();
        set_in(1'b0, 0, '0);
        bus.raddr0 = 7'd3;
        #1;
        check("fwd_hit_two", 64'(bus.fwd_hit0), 64'd1);
        check("fwd_data_two", 64'(bus.fwd_data0), 64'h22);
        bus.drain_en = 1'b1;
        #1;
        check("fwd_while_drain", 64'(bus.fwd_data0), 64'h22);
        step();
        bus.drain_en = 1'b0;
        #1;
        check("fwd_hit_one", 64'(bus.fwd_hit0), 64'd1);
        check("fwd_data_one", 64'(bus.fwd_data0), 64'h22);
        bus.drain_en = 1'b1;
        step();
        bus.drain_en = 1'b0;
        #1;
        check("fwd_hit_none", 64'(bus.fwd_hit0), 64'd0);
        check("fwd_data_none", 64'(bus.fwd_data0), 64'd0);

        // Steady stream: one in, one out each cycle.
        bus.drain_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, BASE + i, 32'(BASE + i));
            #1;
            if (i > 0) begin
                check("stream_count", 64'(bus.count), 64'd1);
                check("stream_waddr", 64'(bus.rf_waddr), 64'(BASE + i - 1));
            end
            step();
        end
        flush();

        // Full with pop: slot frees only for the next cycle.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 10 + i, 32'hB0 + i);
            step();
        end
        set_in(1'b1, 14, 32'hB4);
        bus.drain_en = 1'b1;
        #1;
        check("fullpop_in_ready", 64'(bus.in_ready), 64'd0);
        check("fullpop_count4", 64'(bus.count), 64'd4);
        step();
        bus.drain_en = 1'b0;
        #1;
        check("fullpop_count3", 64'(bus.count), 64'd3);
        check("fullpop_ready_next", 64'(bus.in_ready), 64'd1);
        step();
        set_in(1'b0, 0, '0);
        check("fullpop_count_back", 64'(bus.count), 64'd4);
        flush();

        // Register 0 handling.
        bus.raddr1 = '0;
        set_in(1'b1, 0, 32'hFF);
        #1;
        check("x0_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        set_in(1'b0, 0, '0);
        bus.drain_en = 1'b1;
        #1;
`ifdef RF_WQ_X0_FILTER_EN
        check("x0_count", 64'(bus.count), 64'd0);
        check("x0_rf_we", 64'(bus.rf_we), 64'd0);
        check("x0_hit1", 64'(bus.fwd_hit1), 64'd0);
`else
        check("x0_count", 64'(bus.count), 64'd1);
        check("x0_rf_we", 64'(bus.rf_we), 64'd1);
        check("x0_waddr", 64'(bus.rf_waddr), 64'd0);
        check("x0_hit1", 64'(bus.fwd_hit1), 64'd1);
        check("x0_data1", 64'(bus.fwd_data1), 64'hFF);
`endif
        flush();

        // Randomized traffic with varying drain pressure and occasional resets.
        for (int blk = 0; blk < 10; blk++) begin
            int drain_pct;
            drain_pct = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 50 : 85);
            for (int c = 0; c < 200; c++) begin
                set_in($urandom_range(0, 99) < 65,
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                                   : int'($urandom_range(0, 7)),
                       $urandom);
                bus.drain_en = $urandom_range(0, 99) < drain_pct;
                bus.raddr0   = AW'($urandom_range(0, 7));
                bus.raddr1   = AW'($urandom_range(0, 7));
                if ($urandom_range(0, 249) == 0) begin
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                end else begin
                    step();
                end
            end
        end
        set_in(1'b0, 0, '0);
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
